io_controller: RTL and testbench

IO_CONTROLLER -- requirements
Module: io_controller

---
 rtl/io_controller_pkg.sv | 40 ++++
 rtl/io_tx_fifo.sv | 58 +++++
 rtl/io_controller.sv | 151 +++++++++++++++
 tb/tb_io_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_controller_pkg.sv
// Shared definitions for the io_controller register block: register indices,
// STATUS bit layout and the run/drain/halt state encoding.
package io_controller_pkg;

    localparam int REG_IDX_W = 12;

    localparam logic [REG_IDX_W-1:0] REG_TX_DATA  = 12'd0;
    localparam logic [REG_IDX_W-1:0] REG_STATUS   = 12'd1;
    localparam logic [REG_IDX_W-1:0] REG_CYCLE_LO = 12'd2;
    localparam logic [REG_IDX_W-1:0] REG_CYCLE_HI = 12'd3;
    localparam logic [REG_IDX_W-1:0] REG_GPIO_OUT = 12'd4;
    localparam logic [REG_IDX_W-1:0] REG_GPIO_IN  = 12'd5;
    localparam logic [REG_IDX_W-1:0] REG_HALT     = 12'd4095;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 4;
    localparam int STATUS_COUNT_W   = 5;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } io_state_t;

    // Assemble the STATUS word; unused bits read as zero.
    function automatic logic [15:0] status_word(input logic empty, input logic full,
                                                input logic ovf,
                                                input logic [STATUS_COUNT_W-1:0] count);
        logic [15:0] w;
        w = '0;
        w[STATUS_EMPTY_BIT] = empty;
        w[STATUS_FULL_BIT]  = full;
        w[STATUS_OVF_BIT]   = ovf;
        w[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
        return w;
    endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Console transmit FIFO. The head entry is visible combinationally so a byte
// written into an empty FIFO is presented on the cycle after the push.
// Push while full is accepted only if a pop happens in the same cycle.
module io_tx_fifo #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign data    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/io_controller.sv
// Memory-mapped IO block: console TX FIFO, GPIO, optional cycle counter and a
// run/drain/halt sequencer. Optional feature macro: IO_CYCLE_COUNTER_EN
// (adds a 32-bit cycle counter with a high-half snapshot on CYCLE_LO reads).
import io_controller_pkg::*;

module io_controller #(
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] gpio_out,
    input  logic [15:0] gpio_in,
    output logic        halted
);

    localparam int CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

    io_state_t   state_reg, state_next;
    logic        write_en;
    logic        push;
    logic        pop;
    logic        ovf_event;
    logic        status_read;
    logic        overflow_reg;
    logic [15:0] gpio_out_reg;
    logic [15:0] gpio_sync1_reg, gpio_sync2_reg;
    logic [15:0] read_value_reg, read_mux;
    logic [15:0] cycle_lo, cycle_hi;
    logic [7:0]  fifo_data;
    logic        fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_count;

    // Writes only take effect while running; reads are always served.
    assign write_en    = register_write && (state_reg == ST_RUN);
    assign push        = write_en && (register_index == REG_TX_DATA);
    assign pop         = tx_valid && tx_ready;
    assign ovf_event   = push && fifo_full && !pop;
    assign status_read = register_read && (register_index == REG_STATUS);

    assign tx_valid            = !fifo_empty;
    assign tx_data             = fifo_data;
    assign gpio_out            = gpio_out_reg;
    assign register_read_value = read_value_reg;

    io_tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (register_write_value[7:0]),
        .pop       (pop),
        .data      (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Sticky overflow; a STATUS read clears it unless a new drop lands the same cycle.
    always_ff @(posedge clk) begin
        if (reset)            overflow_reg <= 1'b0;
        else if (ovf_event)   overflow_reg <= 1'b1;
        else if (status_read) overflow_reg <= 1'b0;
    end

    // GPIO output register.
    always_ff @(posedge clk) begin
        if (reset) gpio_out_reg <= '0;
        else if (write_en && register_index == REG_GPIO_OUT) gpio_out_reg <= register_write_value;
    end

    // Two-flop synchroniser for the asynchronous GPIO inputs (deliberately unreset).
    always_ff @(posedge clk) begin
        gpio_sync1_reg <= gpio_in;
        gpio_sync2_reg <= gpio_sync1_reg;
    end

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cycle_count_reg;
    logic [15:0] cycle_snap_reg;

    // Free-running cycle counter that freezes once halted.
    always_ff @(posedge clk) begin
        if (reset) cycle_count_reg <= '0;
        else if (state_reg != ST_HALTED) cycle_count_reg <= cycle_count_reg + 32'd1;
    end

    // Capture the high half when the low half is read so the pair is coherent.
    always_ff @(posedge clk) begin
        if (reset) cycle_snap_reg <= '0;
        else if (register_read && register_index == REG_CYCLE_LO) cycle_snap_reg <= cycle_count_reg[31:16];
    end

    assign cycle_lo = cycle_count_reg[15:0];
    assign cycle_hi = cycle_snap_reg;
`else
    assign cycle_lo = '0;
    assign cycle_hi = '0;
`endif

    // Read decode from pre-write state, so a same-cycle write is not visible.
    always_comb begin
        read_mux = '0;
        case (register_index)
            REG_STATUS:   read_mux = status_word(fifo_empty, fifo_full, overflow_reg,
                                                 STATUS_COUNT_W'(fifo_count));
            REG_CYCLE_LO: read_mux = cycle_lo;
            REG_CYCLE_HI: read_mux = cycle_hi;
            REG_GPIO_OUT: read_mux = gpio_out_reg;
            REG_GPIO_IN:  read_mux = gpio_sync2_reg;
            default:      read_mux = '0;
        endcase
    end

    // Registered read data, held until the next read strobe.
    always_ff @(posedge clk) begin
        if (reset)              read_value_reg <= '0;
        else if (register_read) read_value_reg <= read_mux;
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_RUN;
        else       state_reg <= state_next;
    end

    // Next-state and halted output: HALT write starts the drain, empty FIFO finishes it.
    always_comb begin
        state_next = state_reg;
        halted     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (register_write && register_index == REG_HALT) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) state_next = ST_HALTED;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: state_next = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: directed scenarios plus a randomized
// phase, all checked against a queue-based behavioural model every cycle.
module tb_io_controller;

    localparam int DEPTH = 8;
    localparam logic [11:0] I_TX = 12'd0, I_ST = 12'd1, I_CLO = 12'd2, I_CHI = 12'd3;
    localparam logic [11:0] I_GO = 12'd4, I_GI = 12'd5, I_HALT = 12'd4095;

    logic        clk, reset;
    logic [11:0] register_index;
    logic        register_read, register_write;
    logic [15:0] register_write_value, register_read_value;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [15:0] gpio_out, gpio_in;
    logic        halted;

    io_controller #(.TX_FIFO_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .register_index       (register_index),
        .register_read        (register_read),
        .register_write       (register_write),
        .register_write_value (register_write_value),
        .register_read_value  (register_read_value),
        .tx_data              (tx_data),
        .tx_valid             (tx_valid),
        .tx_ready             (tx_ready),
        .gpio_out             (gpio_out),
        .gpio_in              (gpio_in),
        .halted               (halted)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0]  q[$];
    logic [7:0]  tx_log[$];
    bit          ovf_m, drain_m, halt_m;
    logic [15:0] gpio_m, rv_m, s1_m, s2_m, snap_m;
    logic [31:0] cyc_m;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs, drive strobes, advance model, step clock.
    task automatic do_cycle(input bit wr, input bit rd, input logic [11:0] idx, input logic [15:0] wval);
        int  sz;
        bit  pop, eff_wr, halt_pre;
        logic [15:0] st;
        sz = q.size();
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, sz != 0});
        if (sz != 0) chk("tx_data", {24'b0, tx_data}, {24'b0, q[0]});
        chk("halted", {31'b0, halted}, {31'b0, halt_m});
        chk("gpio_out", {16'b0, gpio_out}, {16'b0, gpio_m});
        chk("read_value", {16'b0, register_read_value}, {16'b0, rv_m});

        register_write = wr;
        register_read = rd;
        register_index = idx;
        register_write_value = wval;
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);

        eff_wr = wr && !drain_m && !halt_m;
        pop = (sz != 0) && tx_ready;
        halt_pre = halt_m;
        if (rd) begin
            st = 16'h0;
            st[0] = (sz == 0);
            st[1] = (sz == DEPTH);
            st[2] = ovf_m;
            st[8:4] = 5'(sz);
            case (idx)
                I_ST: rv_m = st;
`ifdef IO_CYCLE_COUNTER_EN
                I_CLO: begin rv_m = cyc_m[15:0]; snap_m = cyc_m[31:16]; end
                I_CHI: rv_m = snap_m;
`endif
                I_GO: rv_m = gpio_m;
                I_GI: rv_m = s2_m;
                default: rv_m = 16'h0;
            endcase
        end
        if (pop) void'(q.pop_front());
        if (eff_wr && idx == I_TX) begin
            if (sz < DEPTH || pop) q.push_back(wval[7:0]);
            else ovf_m = 1;
        end else if (rd && idx == I_ST) begin
            ovf_m = 0;
        end
        if (eff_wr && idx == I_GO) gpio_m = wval;
        if (drain_m && sz == 0) halt_m = 1;
        if (eff_wr && idx == I_HALT) drain_m = 1;
        if (!halt_pre) cyc_m++;
        s2_m = s1_m;
        s1_m = gpio_in;

        @(posedge clk);
        #1;
        register_write = 0;
        register_read = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 12'd0, 16'd0);
    endtask

    task automatic do_reset();
        reset = 1;
        register_write = 0;
        register_read = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            s2_m = s1_m;
            s1_m = gpio_in;
        end
        reset = 0;
        q.delete();
        ovf_m = 0; drain_m = 0; halt_m = 0;
        gpio_m = 0; rv_m = 0; snap_m = 0; cyc_m = 0;
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_gpio_out", {16'b0, gpio_out}, 32'd0);
        chk("rst_read_value", {16'b0, register_read_value}, 32'd0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_cyc;
        logic [15:0] lo;
        clk = 0; reset = 1; tx_ready = 0; gpio_in = 16'h0;
        register_index = 0; register_read = 0; register_write = 0; register_write_value = 0;
        s1_m = 0; s2_m = 0;
        do_reset();

        // Two bytes streamed in order, FIFO empty afterwards
        tx_ready = 1; tx_log.delete();
        do_cycle(1, 0, I_TX, 16'h0048);
        do_cycle(1, 0, I_TX, 16'h0069);
        idle(3);
        do_cycle(0, 1, I_ST, 0);
        chk("hello_status", {16'b0, register_read_value}, 32'h0001);
        chk("hello_count", tx_log.size(), 2);
        chk("hello_b0", {24'b0, tx_log[0]}, 32'h48);
        chk("hello_b1", {24'b0, tx_log[1]}, 32'h69);

        // Overflow: nine writes into a stalled depth-8 FIFO
        tx_ready = 0; tx_log.delete();
        for (int i = 0; i < 9; i++) do_cycle(1, 0, I_TX, 16'(8'h10 + i));
        do_cycle(0, 1, I_ST, 0);
        chk("ovf_status1", {16'b0, register_read_value}, 32'h0086);
        do_cycle(0, 1, I_ST, 0);
        chk("ovf_status2", {16'b0, register_read_value}, 32'h0082);
        tx_ready = 1;
        idle(10);
        chk("ovf_sent", tx_log.size(), 8);
        chk("ovf_last", {24'b0, tx_log[7]}, 32'h17);

        // Push and pop together while full
        tx_ready = 0;
        for (int i = 0; i < 8; i++) do_cycle(1, 0, I_TX, 16'(8'hC0 + i));
        tx_ready = 1;
        do_cycle(1, 0, I_TX, 16'h00AB);
        tx_ready = 0;
        do_cycle(0, 1, I_ST, 0);
        chk("full_pushpop_status", {16'b0, register_read_value}, 32'h0082);
        tx_ready = 1;
        idle(10);

        // GPIO out/in, and read-before-write on the same index
        do_cycle(1, 0, I_GO, 16'hA5A5);
        chk("gpio_out_drive", {16'b0, gpio_out}, 32'hA5A5);
        do_cycle(0, 1, I_GO, 0);
        chk("gpio_out_read", {16'b0, register_read_value}, 32'hA5A5);
        gpio_in = 16'h1234;
        idle(2);
        do_cycle(0, 1, I_GI, 0);
        chk("gpio_in_read", {16'b0, register_read_value}, 32'h1234);
        do_cycle(1, 1, I_GO, 16'h5A5A);
        chk("rw_same_idx", {16'b0, register_read_value}, 32'hA5A5);
        chk("rw_new_gpio", {16'b0, gpio_out}, 32'h5A5A);

        // Cycle counter coherence across the 16-bit boundary
        do_reset();
`ifdef IO_CYCLE_COUNTER_EN
        idle(70000);
        exp_cyc = cyc_m;
        do_cycle(0, 1, I_CLO, 0);
        lo = register_read_value;
        do_cycle(0, 1, I_CHI, 0);
        chk("cycle_pair", {register_read_value, lo}, exp_cyc);
`else
        exp_cyc = 0;
        do_cycle(0, 1, I_CLO, 0);
        chk("cycle_lo_zero", {16'b0, register_read_value}, exp_cyc);
        do_cycle(0, 1, I_CHI, 0);
        chk("cycle_hi_zero", {16'b0, register_read_value}, exp_cyc);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int op;
            tx_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) gpio_in = 16'($urandom);
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: do_cycle(1, 0, I_TX, 16'($urandom));
                4:          do_cycle(0, 1, I_ST, 0);
                5:          do_cycle(1, 0, I_GO, 16'($urandom));
                6:          do_cycle(0, 1, 12'($urandom_range(0, 5)), 0);
                7:          do_cycle(1, 1, I_GO, 16'($urandom));
                8:          do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                     12'($urandom_range(6, 4094)), 16'($urandom));
                default:    do_cycle(0, 0, 12'd0, 16'd0);
            endcase
        end
        tx_ready = 1;
        idle(12);

        // Halt waits for the FIFO to drain; writes ignored meanwhile
        do_reset();
        tx_ready = 0;
        do_cycle(1, 0, I_GO, 16'h1111);
        for (int i = 0; i < 3; i++) do_cycle(1, 0, I_TX, 16'(8'h30 + i));
        do_cycle(1, 0, I_HALT, 0);
        idle(2);
        chk("drain_not_halted", {31'b0, halted}, 32'd0);
        do_cycle(1, 0, I_GO, 16'h00FF);
        chk("drain_gpio_ignored", {16'b0, gpio_out}, 32'h1111);
        tx_ready = 1;
        idle(3);
        chk("drained_valid", {31'b0, tx_valid}, 32'd0);
        chk("drained_not_yet_halted", {31'b0, halted}, 32'd0);
        idle(1);
        chk("halted_after_drain", {31'b0, halted}, 32'd1);
        do_cycle(0, 1, I_GO, 0);
        chk("halted_read_served", {16'b0, register_read_value}, 32'h1111);
        do_cycle(0, 1, I_CLO, 0);
        lo = register_read_value;
        idle(5);
        do_cycle(0, 1, I_CLO, 0);
        chk("halted_counter_frozen", {16'b0, register_read_value}, {16'b0, lo});
        idle(3);
        chk("halted_persists", {31'b0, halted}, 32'd1);

        // Reset in the middle of a drain discards queued bytes
        do_reset();
        tx_ready = 0;
        for (int i = 0; i < 3; i++) do_cycle(1, 0, I_TX, 16'(8'h70 + i));
        do_cycle(1, 0, I_HALT, 0);
        idle(1);
        do_reset();
        tx_ready = 1;
        idle(5);
        chk("post_reset_no_valid", {31'b0, tx_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
